// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared constants for the multi-channel clock divider
package clk_div_pkg;
  localparam int CTR_W = 31;
  localparam int RST_PERIOD = 300_000;
  localparam int RST_HIGH = 100_000;
  localparam int CH_W = 3;
endpackage

// File: rtl/clk_div_channel.sv
// clk_div_channel: one divider channel with active/pending period and high-count registers
module clk_div_channel #(
  parameter int CTR_W = clk_div_pkg::CTR_W,
  parameter int RST_PERIOD = clk_div_pkg::RST_PERIOD,
  parameter int RST_HIGH = clk_div_pkg::RST_HIGH
) (
  input  logic             CLK100MHZ,
  input  logic             reset,
  input  logic             en,
  input  logic             sync,
  input  logic             wr,
  input  logic [CTR_W-1:0] wr_period,
  input  logic [CTR_W-1:0] wr_high,
  output logic             clk_out,
  output logic             tick
);
  logic [CTR_W-1:0] ctr, period_a, high_a, period_p, high_p;
  logic [CTR_W-1:0] ctr_n, period_n, high_n;
  logic pend, en_q, wrap, apply;
  always_comb begin
    wrap = ctr == period_a - CTR_W'(1);
    apply = wrap || !en || sync;
    period_n = !apply ? period_a : wr ? wr_period : pend ? period_p : period_a;
    high_n = !apply ? high_a : wr ? wr_high : pend ? high_p : high_a;
    ctr_n = (sync || !en_q || wrap) ? '0 : ctr + CTR_W'(1);
  end
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      ctr <= '0;
      period_a <= CTR_W'(RST_PERIOD);
      high_a <= CTR_W'(RST_HIGH);
      period_p <= CTR_W'(RST_PERIOD);
      high_p <= CTR_W'(RST_HIGH);
      pend <= 1'b0;
      en_q <= 1'b0;
      clk_out <= 1'b0;
      tick <= 1'b0;
    end else begin
      period_a <= period_n;
      high_a <= high_n;
      pend <= !apply && (wr || pend);
      if (wr) begin
        period_p <= wr_period;
        high_p <= wr_high;
      end
      en_q <= en;
      ctr <= en ? ctr_n : '0;
      clk_out <= en && (ctr_n < high_n);
      tick <= en && (ctr_n == '0) && (high_n != '0) && ((high_n < period_n) || !en_q);
    end
  end
endmodule

// File: rtl/multi_channel_clock_divider.sv
// multi_channel_clock_divider: write decode, wr_err and sync fan-out over NUM_CH divider channels
module multi_channel_clock_divider #(
  parameter int NUM_CH = 2,
  parameter int CTR_W = clk_div_pkg::CTR_W,
  parameter int RST_PERIOD = clk_div_pkg::RST_PERIOD,
  parameter int RST_HIGH = clk_div_pkg::RST_HIGH
) (
  input  logic                        CLK100MHZ,
  input  logic                        reset,
  input  logic [NUM_CH-1:0]           ch_en,
  input  logic                        sync,
  input  logic                        wr_en,
  input  logic [clk_div_pkg::CH_W-1:0] wr_ch,
  input  logic [CTR_W-1:0]            wr_period,
  input  logic [CTR_W-1:0]            wr_high,
  output logic                        wr_err,
  output logic [NUM_CH-1:0]           clk_out,
  output logic [NUM_CH-1:0]           tick
);
  import clk_div_pkg::*;
  logic bad;
  assign bad = (wr_period < CTR_W'(2)) || (32'(wr_ch) >= 32'(NUM_CH));
  always_ff @(posedge CLK100MHZ) wr_err <= !reset && wr_en && bad;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_div_channel #(
      .CTR_W(CTR_W),
      .RST_PERIOD(RST_PERIOD),
      .RST_HIGH(RST_HIGH)
    ) u_ch (
      .CLK100MHZ(CLK100MHZ),
      .reset(reset),
      .en(ch_en[i]),
      .sync(sync),
      .wr(wr_en && !bad && (wr_ch == CH_W'(i))),
      .wr_period(wr_period),
      .wr_high(wr_high),
      .clk_out(clk_out[i]),
      .tick(tick[i])
    );
  end
endmodule
